contador_gray_param: RTL and testbench



---
 rtl/contador_gray_param.sv | 87 ++++++++
 tb/tb_contador_gray_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/contador_gray_param.sv
// contador_gray_param: parametrised up/down Gray counter with synchronous load, wrap pulse and binary mirror.
// Define GRAY_SATURATE_EN to hold at the count limits (wrap flags a blocked step) instead of wrapping around.
module contador_gray_param #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] dato_carga,
   output logic [WIDTH-1:0] salida_gray,
   output logic [WIDTH-1:0] salida_binaria,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] gray_r;
   logic             wrap_r;
   logic [WIDTH-1:0] cnt_next_s;
   logic             wrap_next_s;

   // Next count and wrap flag: load beats enable, enable selects the direction.
   always_comb begin
      cnt_next_s  = cnt_r;
      wrap_next_s = 1'b0;
      if (load) begin
         cnt_next_s  = dato_carga;
         wrap_next_s = 1'b0;
      end else if (enable) begin
         if (up_down) begin
            if (cnt_r == MAX_C) begin
`ifdef GRAY_SATURATE_EN
               cnt_next_s = cnt_r;
`else
               cnt_next_s = ZERO_C;
`endif
               wrap_next_s = 1'b1;
            end else begin
               cnt_next_s  = cnt_r + ONE_C;
               wrap_next_s = 1'b0;
            end
         end else begin
            if (cnt_r == ZERO_C) begin
`ifdef GRAY_SATURATE_EN
               cnt_next_s = cnt_r;
`else
               cnt_next_s = MAX_C;
`endif
               wrap_next_s = 1'b1;
            end else begin
               cnt_next_s  = cnt_r - ONE_C;
               wrap_next_s = 1'b0;
            end
         end
      end else begin
         cnt_next_s  = cnt_r;
         wrap_next_s = 1'b0;
      end
   end

   // Gray output gets its own register so both codes change on the same edge with no input-to-output path.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cnt_r  <= ZERO_C;
         gray_r <= ZERO_C;
         wrap_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         gray_r <= bin2gray(cnt_next_s);
         wrap_r <= wrap_next_s;
      end
   end

   assign salida_binaria = cnt_r;
   assign salida_gray    = gray_r;
   assign wrap           = wrap_r;

endmodule

// File: tb/tb_contador_gray_param.sv
// Scoreboard bench for contador_gray_param (WIDTH=5): arithmetic reference model feeds a queue, a monitor checks outputs.
module tb_contador_gray_param;
   localparam int W = 5;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         reset_L;
   logic         enable;
   logic         up_down;
   logic         load;
   logic [W-1:0] dato_carga;
   logic [W-1:0] salida_gray;
   logic [W-1:0] salida_binaria;
   logic         wrap;

   contador_gray_param #(.WIDTH(W)) dut (
      .clk(clk), .reset_L(reset_L), .enable(enable), .up_down(up_down), .load(load),
      .dato_carga(dato_carga), .salida_gray(salida_gray), .salida_binaria(salida_binaria), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] bin;
      logic [W-1:0] gray;
      logic         wrp;
      bit           moved;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         mon_item;
   logic [W-1:0] gray_tab[M];
   logic [W-1:0] prev_gray;
   int           m_cnt = 0;
   int           n_checks = 0;
   int           n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reflected-binary table built by mirroring, independent of any xor formula.
   task automatic build_gray_tab();
      logic [W-1:0] one_v;
      one_v = 1;
      gray_tab[0] = '0;
      for (int k = 0; k < W; k++)
         for (int i = 0; i < (1 << k); i++)
            gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | (one_v << k);
   endtask

   task automatic step(input logic en, input logic ud, input logic ld, input logic [W-1:0] d);
      int   n;
      bit   w;
      bit   mv;
      exp_t e;
      @(negedge clk);
      #1;
      enable = en; up_down = ud; load = ld; dato_carga = d;
      w = 1'b0;
      mv = 1'b0;
      if (ld) begin
         m_cnt = int'(d);
      end else if (en) begin
         n = ud ? m_cnt + 1 : m_cnt - 1;
         if (n < 0 || n >= M) begin
            w = 1'b1;
`ifdef GRAY_SATURATE_EN
            n = m_cnt;
`else
            n = (n + M) % M;
`endif
         end
         mv = (n != m_cnt);
         m_cnt = n;
      end
      e.bin = W'(m_cnt); e.gray = gray_tab[m_cnt]; e.wrp = w; e.moved = mv;
      sb_q.push_back(e);
   endtask

   task automatic release_reset();
      exp_t e;
      @(negedge clk);
      #1;
      reset_L = 1'b1; enable = 1'b0; load = 1'b0; up_down = 1'b1;
      e.bin = '0; e.gray = '0; e.wrp = 1'b0; e.moved = 1'b0;
      sb_q.push_back(e);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #3;
      enable = 1'b1; load = 1'b0;
      reset_L = 1'b0;
      m_cnt = 0;
      #1;
      check("async_rst_bin", 32'(salida_binaria), 32'd0);
      check("async_rst_gray", 32'(salida_gray), 32'd0);
      check("async_rst_wrap", 32'(wrap), 32'd0);
      @(posedge clk);
      #1;
      check("held_rst_gray", 32'(salida_gray), 32'd0);
      release_reset();
   endtask

   // Monitor: every cycle presents an output, so pop one expectation per falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_item = sb_q.pop_front();
         check("bin", 32'(salida_binaria), 32'(mon_item.bin));
         check("gray", 32'(salida_gray), 32'(mon_item.gray));
         check("wrap", 32'(wrap), 32'(mon_item.wrp));
         if (mon_item.moved)
            check("gray_hamming", 32'($countones(salida_gray ^ prev_gray)), 32'd1);
         prev_gray = salida_gray;
      end
   end

   initial begin
      build_gray_tab();
      reset_L = 1'b0; enable = 1'b0; up_down = 1'b0; load = 1'b0; dato_carga = '0;
      prev_gray = '0;
      #3;
      check("reset_bin", 32'(salida_binaria), 32'd0);
      check("reset_gray", 32'(salida_gray), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      release_reset();

      // full up-count sweep plus the wrap edge
      for (int i = 0; i < M; i++) step(1'b1, 1'b1, 1'b0, '0);
      // down-count across zero, then one more
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      // load 10 with enable high, then hold
      step(1'b1, 1'b1, 1'b1, W'(10));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, W'($urandom_range(0, M - 1)));
      // reload current value
      step(1'b1, 1'b0, 1'b1, W'(10));
      // count to 7, reset mid-cycle, restart
      step(1'b0, 1'b1, 1'b1, '0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, '0);
      mid_reset();
      step(1'b1, 1'b1, 1'b0, '0);
      // limit behaviour at the top, then turn around
      step(1'b0, 1'b1, 1'b1, W'(M - 1));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      // limit behaviour at the bottom
      step(1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0);

      // random mix
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0)
            mid_reset();
         else
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                 W'($urandom_range(0, M - 1)));
      end

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
